// File: rtl/i2c_tx_shifter_if.sv
// i2c_tx_shifter_if: burst/beat handshake, bit strobe and status bundle for the I2C transmit shifter
interface i2c_tx_shifter_if;
  logic        Start;
  logic [6:0]  Burst;
  logic [3:0]  Size;
  logic [63:0] TxData;
  logic        TxValid;
  logic        ShiftEn;
  logic        AckIn;
  logic        SDAout;
  logic        TxReady;
  logic [6:0]  TXcount;
  logic [6:0]  BurstLeft;
  logic        Busy;
  logic        Done;
  logic        Nack;
  logic        Err;
  modport master (
    output Start, Burst, Size, TxData, TxValid, ShiftEn, AckIn,
    input  SDAout, TxReady, TXcount, BurstLeft, Busy, Done, Nack, Err
  );
  modport slave (
    input  Start, Burst, Size, TxData, TxValid, ShiftEn, AckIn,
    output SDAout, TxReady, TXcount, BurstLeft, Busy, Done, Nack, Err
  );
endinterface

// File: rtl/i2c_tx_shifter.sv
// i2c_tx_shifter: serialises bursts of Size-byte beats MSB-first onto SDA, releasing SDA and sampling ACK after every byte.
// Ports: clk, rst (async active-high); bus.slave carries Start/Burst/Size request, TxData/TxValid/TxReady beat handshake,
// ShiftEn bit strobe, AckIn ACK sample, and SDAout/TXcount/BurstLeft/Busy/Done/Nack/Err status.
module i2c_tx_shifter (
  input logic clk,
  input logic rst,
  i2c_tx_shifter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ACK, DONE} state_t;
  state_t state, nxt;
  logic [63:0] shreg;
  logic [6:0] txc, bl;
  logic [3:0] sz;
  logic sda, nack, err, legal, last_bit, tx_ready, busy, done;
  assign legal = bus.Size != 4'd0 && bus.Size <= 4'd8 && bus.Burst != 7'd0;
  assign last_bit = txc[2:0] == 3'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.Start && legal ? LOAD : IDLE;
      LOAD:    nxt = bus.TxValid ? SHIFT : LOAD;
      SHIFT:   nxt = bus.ShiftEn && last_bit ? ACK : SHIFT;
      ACK:     nxt = !bus.ShiftEn ? ACK : bus.AckIn ? DONE : txc != 7'd0 ? SHIFT : bl == 7'd1 ? DONE : LOAD;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    tx_ready = state == LOAD;
    busy = state != IDLE;
    done = state == DONE;
  end
  // The beat is left-justified at load so the next bit is always shreg[63].
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_sda_reset: begin
        sda <= 1'b1;
        shreg <= '0;
        txc <= '0;
        bl <= '0;
        sz <= '0;
        nack <= 1'b0;
        err <= 1'b0;
      end
    end else begin
      err <= state == IDLE && bus.Start && !legal;
      sda <= 1'b1;
      case (state)
        IDLE: if (bus.Start && legal) begin
          sz <= bus.Size;
          bl <= bus.Burst;
          nack <= 1'b0;
        end
        LOAD: if (bus.TxValid) begin
          shreg <= bus.TxData << (7'd64 - {sz, 3'b000});
          txc <= {sz, 3'b000};
        end
        SHIFT: begin
          sda <= bus.ShiftEn ? shreg[63] : sda;
          if (bus.ShiftEn) begin
            shreg <= {shreg[62:0], 1'b0};
            txc <= txc - 7'd1;
          end
        end
        ACK: if (bus.ShiftEn) begin
          if (bus.AckIn) nack <= 1'b1;
          else if (txc == 7'd0) bl <= bl - 7'd1;
        end
        default: ;
      endcase
    end
  assign bus.SDAout = sda;
  assign bus.TxReady = tx_ready;
  assign bus.TXcount = txc;
  assign bus.BurstLeft = bl;
  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.Nack = nack;
  assign bus.Err = err;
endmodule

// File: tb/tb_i2c_tx_shifter.sv
// tb_i2c_tx_shifter: directed self-checking bench for i2c_tx_shifter
module tb_i2c_tx_shifter;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  i2c_tx_shifter_if bus();
  i2c_tx_shifter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [3:0] s, input logic [6:0] b);
    bus.Start = 1'b1;
    bus.Size = s;
    bus.Burst = b;
    tick();
    bus.Start = 1'b0;
  endtask
  task automatic load(input logic [63:0] d);
    bus.TxValid = 1'b1;
    bus.TxData = d;
    tick();
    bus.TxValid = 1'b0;
  endtask
  task automatic strobe(input logic a);
    bus.ShiftEn = 1'b1;
    bus.AckIn = a;
    tick();
    bus.ShiftEn = 1'b0;
    bus.AckIn = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus.SDAout, bus.TxReady, bus.TXcount, bus.BurstLeft, bus.Busy, bus.Done, bus.Nack, bus.Err} !== {1'b1, 1'b0, 7'd0, 7'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h", {bus.SDAout, bus.TxReady, bus.TXcount, bus.BurstLeft, bus.Busy, bus.Done, bus.Nack, bus.Err}, {1'b1, 1'b0, 7'd0, 7'd0, 4'b0000});
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_single_byte;
    logic [7:0] d = 8'hA5;
    start(4'd1, 7'd1);
    n_checks++;
    if ({bus.TxReady, bus.Busy, bus.BurstLeft} !== {1'b1, 1'b1, 7'd1}) begin
      n_fail++;
      $display("FAIL single_load: got %h want %h", {bus.TxReady, bus.Busy, bus.BurstLeft}, {1'b1, 1'b1, 7'd1});
    end
    load({56'd0, d});
    n_checks++;
    if ({bus.TxReady, bus.TXcount} !== {1'b0, 7'd8}) begin
      n_fail++;
      $display("FAIL single_txcount_load: got %h want %h", {bus.TxReady, bus.TXcount}, {1'b0, 7'd8});
    end
    for (int i = 7; i >= 0; i--) begin
      strobe(1'b0);
      n_checks++;
      if ({bus.SDAout, bus.TXcount} !== {d[i], 7'(i)}) begin
        n_fail++;
        $display("FAIL single_bit%0d: got %h want %h", i, {bus.SDAout, bus.TXcount}, {d[i], 7'(i)});
      end
      tick();
    end
    n_checks++;
    if (bus.SDAout !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack_release: got %b want 1", bus.SDAout);
    end
    strobe(1'b0);
    n_checks++;
    if ({bus.Done, bus.Busy, bus.BurstLeft, bus.Nack} !== {1'b1, 1'b1, 7'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_done: got %h want %h", {bus.Done, bus.Busy, bus.BurstLeft, bus.Nack}, {1'b1, 1'b1, 7'd0, 1'b0});
    end
    tick();
    n_checks++;
    if ({bus.Done, bus.Busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: got %b want 00", {bus.Done, bus.Busy});
    end
  endtask
  task automatic test_two_beats;
    logic [15:0] beats [2];
    int idx;
    beats[0] = 16'h1234;
    beats[1] = 16'hABCD;
    start(4'd2, 7'd2);
    for (int b = 0; b < 2; b++) begin
      n_checks++;
      if ({bus.TxReady, bus.BurstLeft} !== {1'b1, 7'(2 - b)}) begin
        n_fail++;
        $display("FAIL two_load%0d: got %h want %h", b, {bus.TxReady, bus.BurstLeft}, {1'b1, 7'(2 - b)});
      end
      load({48'd0, beats[b]});
      n_checks++;
      if (bus.TXcount !== 7'd16) begin
        n_fail++;
        $display("FAIL two_txcount%0d: got %0d want 16", b, bus.TXcount);
      end
      for (int y = 0; y < 2; y++) begin
        for (int i = 7; i >= 0; i--) begin
          idx = (1 - y) * 8 + i;
          strobe(1'b0);
          n_checks++;
          if ({bus.SDAout, bus.TXcount} !== {beats[b][idx], 7'(idx)}) begin
            n_fail++;
            $display("FAIL two_bit b%0d idx%0d: got %h want %h", b, idx, {bus.SDAout, bus.TXcount}, {beats[b][idx], 7'(idx)});
          end
          tick();
        end
        n_checks++;
        if (bus.SDAout !== 1'b1) begin
          n_fail++;
          $display("FAIL two_ack_release b%0d y%0d: got %b want 1", b, y, bus.SDAout);
        end
        strobe(1'b0);
        if (y == 0) begin
          n_checks++;
          if ({bus.BurstLeft, bus.TxReady, bus.TXcount} !== {7'(2 - b), 1'b0, 7'd8}) begin
            n_fail++;
            $display("FAIL two_mid_ack%0d: got %h want %h", b, {bus.BurstLeft, bus.TxReady, bus.TXcount}, {7'(2 - b), 1'b0, 7'd8});
          end
        end else if (b == 0) begin
          n_checks++;
          if ({bus.BurstLeft, bus.TxReady, bus.Done} !== {7'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL two_beat_end: got %h want %h", {bus.BurstLeft, bus.TxReady, bus.Done}, {7'd1, 1'b1, 1'b0});
          end
        end else begin
          n_checks++;
          if ({bus.BurstLeft, bus.Done, bus.Nack} !== {7'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL two_burst_end: got %h want %h", {bus.BurstLeft, bus.Done, bus.Nack}, {7'd0, 1'b1, 1'b0});
          end
        end
      end
    end
    tick();
    n_checks++;
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL two_idle: got %b want 0", bus.Busy);
    end
  endtask
  task automatic test_nack;
    logic [15:0] d = 16'h1234;
    start(4'd2, 7'd2);
    load({48'd0, d});
    for (int i = 15; i >= 8; i--) begin
      strobe(1'b0);
      tick();
    end
    strobe(1'b0);
    n_checks++;
    if ({bus.TXcount, bus.TxReady, bus.Nack} !== {7'd8, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL nack_first_ack: got %h want %h", {bus.TXcount, bus.TxReady, bus.Nack}, {7'd8, 1'b0, 1'b0});
    end
    for (int i = 7; i >= 0; i--) begin
      strobe(1'b0);
      n_checks++;
      if (bus.SDAout !== d[i]) begin
        n_fail++;
        $display("FAIL nack_bit%0d: got %b want %b", i, bus.SDAout, d[i]);
      end
      tick();
    end
    strobe(1'b1);
    n_checks++;
    if ({bus.Nack, bus.Done, bus.BurstLeft} !== {1'b1, 1'b1, 7'd2}) begin
      n_fail++;
      $display("FAIL nack_done: got %h want %h", {bus.Nack, bus.Done, bus.BurstLeft}, {1'b1, 1'b1, 7'd2});
    end
    tick();
    tick();
    n_checks++;
    if ({bus.Busy, bus.TxReady, bus.Nack, bus.BurstLeft} !== {1'b0, 1'b0, 1'b1, 7'd2}) begin
      n_fail++;
      $display("FAIL nack_idle: got %h want %h", {bus.Busy, bus.TxReady, bus.Nack, bus.BurstLeft}, {1'b0, 1'b0, 1'b1, 7'd2});
    end
    start(4'd1, 7'd1);
    n_checks++;
    if ({bus.Nack, bus.TxReady} !== 2'b01) begin
      n_fail++;
      $display("FAIL nack_clear: got %b want 01", {bus.Nack, bus.TxReady});
    end
    load(64'hFF);
    repeat (8) begin
      strobe(1'b0);
      tick();
    end
    strobe(1'b0);
    tick();
    n_checks++;
    if ({bus.Busy, bus.Nack} !== 2'b00) begin
      n_fail++;
      $display("FAIL nack_rerun: got %b want 00", {bus.Busy, bus.Nack});
    end
  endtask
  task automatic test_illegal;
    logic [3:0] sz [3];
    logic [6:0] bu [3];
    sz[0] = 4'd0; bu[0] = 7'd1;
    sz[1] = 4'd9; bu[1] = 7'd1;
    sz[2] = 4'd1; bu[2] = 7'd0;
    for (int k = 0; k < 3; k++) begin
      start(sz[k], bu[k]);
      n_checks++;
      if ({bus.Err, bus.Busy, bus.TxReady} !== 3'b100) begin
        n_fail++;
        $display("FAIL illegal%0d_err: got %b want 100", k, {bus.Err, bus.Busy, bus.TxReady});
      end
      tick();
      n_checks++;
      if ({bus.Err, bus.Busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL illegal%0d_pulse: got %b want 00", k, {bus.Err, bus.Busy});
      end
    end
  endtask
  task automatic test_stalls;
    start(4'd1, 7'd1);
    repeat (10) tick();
    n_checks++;
    if ({bus.TxReady, bus.Busy, bus.BurstLeft} !== {1'b1, 1'b1, 7'd1}) begin
      n_fail++;
      $display("FAIL stall_load: got %h want %h", {bus.TxReady, bus.Busy, bus.BurstLeft}, {1'b1, 1'b1, 7'd1});
    end
    load(64'h80);
    strobe(1'b0);
    n_checks++;
    if ({bus.SDAout, bus.TXcount} !== {1'b1, 7'd7}) begin
      n_fail++;
      $display("FAIL stall_first_bit: got %h want %h", {bus.SDAout, bus.TXcount}, {1'b1, 7'd7});
    end
    tick();
    bus.Start = 1'b1;
    bus.Size = 4'd2;
    bus.Burst = 7'd5;
    tick();
    bus.Start = 1'b0;
    n_checks++;
    if ({bus.BurstLeft, bus.Err, bus.TXcount, bus.TxReady} !== {7'd1, 1'b0, 7'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_start_ignored: got %h want %h", {bus.BurstLeft, bus.Err, bus.TXcount, bus.TxReady}, {7'd1, 1'b0, 7'd7, 1'b0});
    end
    repeat (5) tick();
    n_checks++;
    if ({bus.SDAout, bus.TXcount, bus.Busy} !== {1'b1, 7'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_shift_hold: got %h want %h", {bus.SDAout, bus.TXcount, bus.Busy}, {1'b1, 7'd7, 1'b1});
    end
    for (int i = 6; i >= 0; i--) begin
      strobe(1'b0);
      n_checks++;
      if ({bus.SDAout, bus.TXcount} !== {1'b0, 7'(i)}) begin
        n_fail++;
        $display("FAIL stall_bit%0d: got %h want %h", i, {bus.SDAout, bus.TXcount}, {1'b0, 7'(i)});
      end
      tick();
    end
    strobe(1'b0);
    n_checks++;
    if ({bus.Done, bus.BurstLeft} !== {1'b1, 7'd0}) begin
      n_fail++;
      $display("FAIL stall_done: got %h want %h", {bus.Done, bus.BurstLeft}, {1'b1, 7'd0});
    end
    tick();
  endtask
  task automatic test_reset_mid;
    logic [7:0] d = 8'h5A;
    start(4'd1, 7'd1);
    load(64'h00);
    repeat (3) begin
      strobe(1'b0);
      tick();
    end
    n_checks++;
    if ({bus.SDAout, bus.TXcount} !== {1'b0, 7'd5}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %h want %h", {bus.SDAout, bus.TXcount}, {1'b0, 7'd5});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.SDAout, bus.TxReady, bus.TXcount, bus.BurstLeft, bus.Busy, bus.Done, bus.Nack, bus.Err} !== {1'b1, 1'b0, 7'd0, 7'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h want %h", {bus.SDAout, bus.TxReady, bus.TXcount, bus.BurstLeft, bus.Busy, bus.Done, bus.Nack, bus.Err}, {1'b1, 1'b0, 7'd0, 7'd0, 4'b0000});
    end
    tick();
    rst = 1'b0;
    tick();
    start(4'd1, 7'd1);
    n_checks++;
    if ({bus.TxReady, bus.BurstLeft} !== {1'b1, 7'd1}) begin
      n_fail++;
      $display("FAIL rstmid_restart: got %h want %h", {bus.TxReady, bus.BurstLeft}, {1'b1, 7'd1});
    end
    load({56'd0, d});
    for (int i = 7; i >= 0; i--) begin
      strobe(1'b0);
      n_checks++;
      if ({bus.SDAout, bus.TXcount} !== {d[i], 7'(i)}) begin
        n_fail++;
        $display("FAIL rstmid_bit%0d: got %h want %h", i, {bus.SDAout, bus.TXcount}, {d[i], 7'(i)});
      end
      tick();
    end
    strobe(1'b0);
    n_checks++;
    if ({bus.Done, bus.BurstLeft, bus.Nack} !== {1'b1, 7'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_done: got %h want %h", {bus.Done, bus.BurstLeft, bus.Nack}, {1'b1, 7'd0, 1'b0});
    end
    tick();
  endtask
  initial begin
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.Burst = '0;
    bus.Size = '0;
    bus.TxData = '0;
    bus.TxValid = 1'b0;
    bus.ShiftEn = 1'b0;
    bus.AckIn = 1'b0;
    test_reset();
    test_single_byte();
    test_two_beats();
    test_nack();
    test_illegal();
    test_stalls();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_tx_shifter.md
# i2c_tx_shifter

Transmit-side bit engine of the I2C interface, the counterpart of the receive bit counter. It accepts a burst of data beats of `Size` bytes each and serialises every beat MSB-first onto `SDAout`, one bit per `ShiftEn` strobe from the SCL generator. After each byte it releases SDA for the acknowledge slot and samples the slave's ACK. It tracks bits remaining in the beat (`TXcount`) and beats remaining in the burst (`BurstLeft`), and aborts the burst on NACK.

## Interface
- No parameters; widths fixed: `Burst` 7 bits, `Size` 4 bits (bytes per beat, legal 1..8), beat data 64 bits.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: asynchronous active-high reset.
- `Start` input 1: request a burst; sampled only in IDLE.
- `Burst` input 7: beats in burst, captured on accepted `Start`; legal 1..127.
- `Size` input 4: bytes per beat, captured on accepted `Start`; legal 1..8.
- `TxData` input 64: beat data; bits `[Size*8-1:0]` are sent, MSB first.
- `TxValid` input 1: `TxData` valid.
- `ShiftEn` input 1: one-cycle bit strobe from the SCL generator.
- `AckIn` input 1: SDA sampled in the ACK slot; 0 = ACK, 1 = NACK.
- `SDAout` output 1: SDA drive value, 1 = released.
- `TxReady` output 1: engine can accept a beat.
- `TXcount` output 7: bits remaining in the current beat.
- `BurstLeft` output 7: beats not yet completed.
- `Busy` output 1: high in every state except IDLE.
- `Done` output 1: one-cycle pulse at burst end.
- `Nack` output 1: sticky, set when a NACK ends the burst.
- `Err` output 1: one-cycle pulse when `Start` is rejected.

## Operation
- Reset values: `SDAout`=1, `TxReady`=0, `TXcount`=0, `BurstLeft`=0, `Busy`=0, `Done`=0, `Nack`=0, `Err`=0, state IDLE, shift register 0.
- States: IDLE, LOAD, SHIFT, ACK, DONE.
- IDLE, `Start`=1:
  - If `Size`==0, `Size`>8 or `Burst`==0: pulse `Err`, stay IDLE.
  - Otherwise: capture `Size` and `Burst`, set `BurstLeft`=`Burst`, clear `Nack`, go to LOAD.
- LOAD: `TxReady`=1. On `TxValid`=1, load the shift register from `TxData`, set `TXcount`=`Size*8` (7-bit, max 64), go to SHIFT. Without `TxValid`, remain in LOAD indefinitely.
- SHIFT, on `ShiftEn`=1:
  - `SDAout` <= shreg[`TXcount`-1]; `TXcount` <= `TXcount`-1.
  - If the old `TXcount[2:0]`==1 (last bit of a byte), go to ACK.
- ACK: `SDAout`=1 on entry. On `ShiftEn`=1, sample `AckIn`:
  - `AckIn`=1: set `Nack`, go to DONE. `BurstLeft` is not decremented.
  - `AckIn`=0, `TXcount`!=0: return to SHIFT.
  - `AckIn`=0, `TXcount`==0: `BurstLeft` <= `BurstLeft`-1. Go to DONE if the new value is 0, otherwise go to LOAD.
- DONE: `Done`=1 for one cycle, `SDAout`=1, then IDLE.
- `Start` outside IDLE is ignored, with no `Err`.
- `TxValid` outside LOAD is ignored.
- `ShiftEn` outside SHIFT and ACK is ignored.
- Arithmetic: `TXcount` never wraps (exit to ACK occurs before it goes below 0). `BurstLeft` is decremented only on ACK at beat end.

## Timing
- `Start` to LOAD: 1 cycle. `TxReady` is high in the cycle after `Start` is accepted.
- Beat handshake: transfer occurs on the edge where `TxReady` && `TxValid`. `TxReady` drops in the next cycle.
- Bit latency: `SDAout` reflects the new bit from the clock edge on which `ShiftEn` is sampled high.
- ACK release: `SDAout`=1 from the edge that sends the byte's bit 0 plus the transition edge; it stays 1 through the ACK slot.
- Each byte needs 9 `ShiftEn` strobes (8 data, 1 ACK).
- Beat-to-beat gap: 1 LOAD cycle minimum, extended while `TxValid`=0.
- `Done` is asserted the cycle after the final ACK sample. `Busy` falls in the cycle after `Done`.
- `rst` asserted in any state forces reset values immediately, independent of `clk`. The partial beat is discarded.

## Test plan
- Single byte, normal: `Size`=1, `Burst`=1, `TxData`=0xA5, `ShiftEn` every cycle, `AckIn`=0.
  -> `SDAout` 1,0,1,0,0,1,0,1, then 1 in ACK; `TXcount` 8→0; `Done` pulses once; `BurstLeft`=0; `Nack`=0.
- Two beats of two bytes: `Size`=2, `Burst`=2, beats 0x1234 then 0xABCD, all ACK.
  -> 36 `ShiftEn` strobes; bit stream 0x12, 0x34, 0xAB, 0xCD; `BurstLeft` 2→1→0; one LOAD between beats.
- NACK mid-burst: as the two-beat case, `AckIn`=1 in the second byte's ACK slot.
  -> `Nack`=1, `Done` pulses, `BurstLeft` stays 2, no further LOAD; `Nack` clears on the next accepted `Start`.
- Illegal start, each case separately: `Size`=0, `Size`=9, `Burst`=0.
  -> `Err` pulses for one cycle each; `Busy` stays 0.
- Stalls and ignored requests: `TxValid` held low 10 cycles in LOAD; `Start` pulsed during SHIFT; `ShiftEn` held low 5 cycles in SHIFT.
  -> engine holds state, outputs unchanged, no extra burst started.
- Reset mid-operation: assert `rst` in SHIFT with `TXcount`=5.
  -> all outputs return to reset values without a clock edge; a subsequent `Start` runs a clean burst.
